// File: rtl/rx_matrix_arbiter_pkg.sv
// Shared definitions for the matrix receiver and its two-requester arbiter:
// FSM state encoding, action codes, the transfer descriptor layout and the
// action-valid check.
package rx_matrix_arbiter_pkg;

  localparam int unsigned ST_W  = 3;
  localparam int unsigned COL_W = 2;
  localparam int unsigned ACT_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [ST_W-1:0] ST_SETUP     = 3'd1;
  localparam logic [ST_W-1:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [ST_W-1:0] ST_XFER      = 3'd3;
  localparam logic [ST_W-1:0] ST_DONE      = 3'd4;

  localparam logic [ACT_W-1:0] ACT_CELL = 3'd2;
  localparam logic [ACT_W-1:0] ACT_ROW  = 3'd3;
  localparam logic [ACT_W-1:0] ACT_COL  = 3'd4;
  localparam logic [ACT_W-1:0] ACT_ALL  = 3'd5;

  // Transfer descriptor as presented to the receiver's config inputs.
  typedef struct packed {
    logic             row;
    logic [COL_W-1:0] col;
    logic [ACT_W-1:0] act;
  } desc_t;

  function automatic logic act_valid(input logic [ACT_W-1:0] act);
    return (act == ACT_CELL) || (act == ACT_ROW) ||
           (act == ACT_COL)  || (act == ACT_ALL);
  endfunction

endpackage

// File: rtl/rx_matrix_arbiter_xfer_timer.sv
// Saturating state timer with a runtime terminal-count limit.
// Ports:
//   clk, rst     - clock, async active-low reset
//   clr_i        - synchronous clear (wins over enable)
//   en_i         - count enable
//   limit_i      - terminal count value
//   tc_c_o       - combinational: count equals limit
module xfer_timer #(
  parameter int unsigned TW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [TW-1:0] limit_i,
  output logic          tc_c_o
);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  // Count up and stick at all-ones rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != {TW{1'b1}})) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_c_o = (cnt_q == limit_i);

endmodule

// File: rtl/rx_matrix_arbiter.sv
// Round-robin arbiter sharing one serial matrix receiver between two
// requesters. Latches the winner's descriptor onto the receiver config
// outputs, opens the winner's serial line onto rx, follows the receiver's
// busy to detect completion and times out stalled starts/transfers.
// Ports:
//   clk, rst                  - clock, async active-low reset
//   req0/req1                 - level requests, held until matching done
//   row*_i, col*_i, act*_i    - per-requester descriptor
//   rx0/rx1                   - requester serial lines (idle high)
//   busy                      - receiver busy
//   row, col0/1, action0/1/2  - receiver config outputs
//   rx                        - registered mux of the granted serial line
//   gnt                       - one-hot grant
//   done, err                 - one-cycle completion pulse and its status
module rx_matrix_arbiter
  import rx_matrix_arbiter_pkg::*;
#(
  parameter int unsigned START_TO = 64,
  parameter int unsigned XFER_TO  = 4096,
  parameter int unsigned TW       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic       row0_i,
  input  logic       row1_i,
  input  logic [1:0] col0_i,
  input  logic [1:0] col1_i,
  input  logic [2:0] act0_i,
  input  logic [2:0] act1_i,
  input  logic       rx0,
  input  logic       rx1,
  input  logic       busy,
  output logic       row,
  output logic       col0,
  output logic       col1,
  output logic       action0,
  output logic       action1,
  output logic       action2,
  output logic       rx,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic       err
);

  localparam logic [TW-1:0] START_LIM = TW'(START_TO - 1);
  localparam logic [TW-1:0] XFER_LIM  = TW'(XFER_TO - 1);

  logic [ST_W-1:0] state_q, state_d;
  logic            owner_q, owner_d;
  logic            prio_q, prio_d;
  desc_t           cfg_q, cfg_d;
  logic [1:0]      gnt_q, gnt_d;
  logic [1:0]      done_q, done_d;
  logic            err_q, err_d;
  logic            rx_q, rx_d;

  desc_t           desc0_c, desc1_c;
  logic            win_c;
  logic            line_c;
  logic [1:0]      owner_oh_c;
  logic            fin_c, fin_err_c;
  logic            tmr_clr_c, tmr_en_c, tmr_tc_c;
  logic [TW-1:0]   tmr_limit_c;

  assign desc0_c = '{row: row0_i, col: col0_i, act: act0_i};
  assign desc1_c = '{row: row1_i, col: col1_i, act: act1_i};

  // prio only breaks ties; a lone requester always wins.
  assign win_c      = (req0 && req1) ? prio_q : req1;
  assign line_c     = owner_q ? rx1 : rx0;
  assign owner_oh_c = owner_q ? 2'b10 : 2'b01;

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    prio_d    = prio_q;
    cfg_d     = cfg_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    err_d     = 1'b0;
    rx_d      = 1'b1;
    fin_c     = 1'b0;
    fin_err_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Hold off while a timed-out transfer still occupies the receiver.
        if (!busy && (req0 || req1)) begin
          owner_d = win_c;
          cfg_d   = win_c ? desc1_c : desc0_c;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (act_valid(cfg_q.act)) begin
          gnt_d   = owner_oh_c;
          rx_d    = line_c;
          state_d = ST_WAIT_BUSY;
        end else begin
          fin_c     = 1'b1;
          fin_err_c = 1'b1;
        end
      end
      ST_WAIT_BUSY: begin
        rx_d = line_c;
        if (busy) begin
          state_d = ST_XFER;
        end else if (tmr_tc_c) begin
          fin_c     = 1'b1;
          fin_err_c = 1'b1;
        end
      end
      ST_XFER: begin
        rx_d = line_c;
        if (!busy) begin
          fin_c = 1'b1;
        end else if (tmr_tc_c) begin
          fin_c     = 1'b1;
          fin_err_c = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Common completion: pulse done, close the line, hand priority over.
    if (fin_c) begin
      state_d = ST_DONE;
      done_d  = owner_oh_c;
      err_d   = fin_err_c;
      gnt_d   = '0;
      rx_d    = 1'b1;
      prio_d  = ~owner_q;
    end
  end

  // Timer restarts on every state change and only runs while waiting on busy.
  assign tmr_clr_c   = (state_d != state_q);
  assign tmr_en_c    = (state_q == ST_WAIT_BUSY) || (state_q == ST_XFER);
  assign tmr_limit_c = (state_q == ST_XFER) ? XFER_LIM : START_LIM;

  xfer_timer #(
    .TW(TW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (tmr_clr_c),
    .en_i    (tmr_en_c),
    .limit_i (tmr_limit_c),
    .tc_c_o  (tmr_tc_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
      cfg_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      rx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      cfg_q   <= cfg_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rx_q    <= rx_d;
    end
  end

  assign row     = cfg_q.row;
  assign col0    = cfg_q.col[0];
  assign col1    = cfg_q.col[1];
  assign action0 = cfg_q.act[0];
  assign action1 = cfg_q.act[1];
  assign action2 = cfg_q.act[2];
  assign rx      = rx_q;
  assign gnt     = gnt_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule
